// File: rtl/demux_1to8_buf_if.sv
// Handshake and lane bus for the 1-to-8 buffered demultiplexer.
// Optional broadcast input is present only when DEMUX_BCAST_EN is defined.
interface demux_1to8_buf_if #(
    parameter int k = 1
);
    logic [k-1:0] I;
    logic         I_VALID;
    logic         I_READY;
    logic [2:0]   SEL;
    logic [k-1:0] A;
    logic [k-1:0] B;
    logic [k-1:0] C;
    logic [k-1:0] D;
    logic [k-1:0] E;
    logic [k-1:0] F;
    logic [k-1:0] G;
    logic [k-1:0] H;
    logic [7:0]   O_VALID;
    logic [7:0]   O_READY;
    logic [3:0]   OCC;
`ifdef DEMUX_BCAST_EN
    logic         BCAST;
`endif

    // Producer/consumer side (testbench or upstream logic).
    modport master (
`ifdef DEMUX_BCAST_EN
        output BCAST,
`endif
        output I, I_VALID, SEL, O_READY,
        input  I_READY, A, B, C, D, E, F, G, H, O_VALID, OCC
    );

    // Demux side.
    modport slave (
`ifdef DEMUX_BCAST_EN
        input  BCAST,
`endif
        input  I, I_VALID, SEL, O_READY,
        output I_READY, A, B, C, D, E, F, G, H, O_VALID, OCC
    );
endinterface

// File: rtl/demux_1to8_buf.sv
// Registered 1-to-8 demultiplexer with a one-entry holding register per lane.
// A word accepted on the input handshake lands in lane[SEL] one cycle later.
// A lane drained and refilled in the same cycle stays valid, so a single lane
// sustains one word per cycle.
// Optional feature macro: DEMUX_BCAST_EN adds BCAST, which writes all eight
// lanes at once when every lane is free or draining.
module demux_1to8_buf #(
    parameter int k = 1
) (
    input logic              clk,
    input logic              rst,
    demux_1to8_buf_if.slave  bus
);

    logic [7:0]   valid_q;
    logic [7:0]   valid_d;
    logic [3:0]   occ_q;
    logic [3:0]   occ_d;
    logic [k-1:0] lane_q [8];

    logic [7:0]   onehot_sel;
    logic [7:0]   wr_mask;
    logic [7:0]   drain;
    logic         sel_free;
    logic         in_ready;
    logic         in_xfer;
`ifdef DEMUX_BCAST_EN
    logic         all_free;
`endif

    // Input acceptance, lane write enables, next valid vector and its popcount.
    always_comb begin
        onehot_sel = 8'h01 << bus.SEL;
        sel_free   = ~valid_q[bus.SEL] | bus.O_READY[bus.SEL];
        drain      = valid_q & bus.O_READY;
`ifdef DEMUX_BCAST_EN
        all_free   = &(~valid_q | bus.O_READY);
        in_ready   = bus.BCAST ? all_free : sel_free;
        in_xfer    = bus.I_VALID & in_ready;
        wr_mask    = in_xfer ? (bus.BCAST ? 8'hFF : onehot_sel) : 8'h00;
`else
        in_ready   = sel_free;
        in_xfer    = bus.I_VALID & in_ready;
        wr_mask    = in_xfer ? onehot_sel : 8'h00;
`endif
        // A refill wins over a drain on the same lane.
        valid_d    = (valid_q & ~drain) | wr_mask;
        occ_d      = 4'd0;
        for (int n = 0; n < 8; n++) begin
            occ_d = occ_d + 4'(valid_d[n]);
        end
    end

    // Valid bits and occupancy; reset discards all buffered and in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 8'h00;
            occ_q   <= 4'd0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Lane data registers change only when written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                lane_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (wr_mask[n]) begin
                    lane_q[n] <= bus.I;
                end
            end
        end
    end

    assign bus.I_READY = in_ready;
    assign bus.O_VALID = valid_q;
    assign bus.OCC     = occ_q;
    assign bus.A       = lane_q[0];
    assign bus.B       = lane_q[1];
    assign bus.C       = lane_q[2];
    assign bus.D       = lane_q[3];
    assign bus.E       = lane_q[4];
    assign bus.F       = lane_q[5];
    assign bus.G       = lane_q[6];
    assign bus.H       = lane_q[7];

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Self-checking bench for demux_1to8_buf (k=8): directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a lane model.
module tb_demux_1to8_buf;

    localparam int K = 8;

    logic clk;
    logic rst;
    logic tb_bcast;

    demux_1to8_buf_if #(.k(K)) bus ();

    demux_1to8_buf #(.k(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef DEMUX_BCAST_EN
    assign bus.BCAST = tb_bcast;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: eight lanes, each either holding a word or empty.
    logic [7:0] m_lane  [8];
    bit         m_full  [8];
    bit         chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_out(input int n);
        case (n)
            0: return bus.A;
            1: return bus.B;
            2: return bus.C;
            3: return bus.D;
            4: return bus.E;
            5: return bus.F;
            6: return bus.G;
            default: return bus.H;
        endcase
    endfunction

    // Can the model take the presented word: the target lane (or every lane
    // for a broadcast) must be empty or be handing its word off this cycle.
    function automatic bit model_ready();
        bit r;
        if (tb_bcast) begin
            r = 1;
            for (int n = 0; n < 8; n++)
                if (m_full[n] && !bus.O_READY[n]) r = 0;
        end else begin
            r = !m_full[bus.SEL] || bus.O_READY[bus.SEL];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit xf;
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                m_full[n] = 0;
                m_lane[n] = 8'h00;
            end
            chk_en = 1;
        end else begin
            xf = bus.I_VALID && model_ready();
            for (int n = 0; n < 8; n++)
                if (m_full[n] && bus.O_READY[n]) m_full[n] = 0;
            if (xf) begin
                for (int n = 0; n < 8; n++) begin
                    if (tb_bcast || n == int'(bus.SEL)) begin
                        m_lane[n] = bus.I;
                        m_full[n] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_v;
        int         exp_occ;
        if (chk_en) begin
            exp_v   = 8'h00;
            exp_occ = 0;
            for (int n = 0; n < 8; n++) begin
                exp_v[n] = m_full[n];
                if (m_full[n]) exp_occ++;
            end
            chk("m_i_ready", {31'd0, bus.I_READY}, {31'd0, model_ready()});
            chk("m_o_valid", {24'd0, bus.O_VALID}, {24'd0, exp_v});
            chk("m_occ", {28'd0, bus.OCC}, exp_occ);
            for (int n = 0; n < 8; n++)
                chk($sformatf("m_lane%0d", n), {24'd0, lane_out(n)}, {24'd0, m_lane[n]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] s, input logic [7:0] d);
        bus.SEL = s; bus.I = d; bus.I_VALID = 1'b1;
        tick();
        bus.I_VALID = 1'b0;
    endtask

    task automatic drain_all();
        bus.I_VALID = 1'b0; tb_bcast = 1'b0; bus.O_READY = 8'hFF;
        tick();
        bus.O_READY = 8'h00;
    endtask

    initial begin
        rst = 1'b1; tb_bcast = 1'b0;
        bus.I = '0; bus.I_VALID = 1'b0; bus.SEL = 3'd0; bus.O_READY = 8'h00;
        tick(); tick();
        rst = 1'b0;

        // Reset state, then a single word to lane D.
        @(negedge clk);
        chk("rst_o_valid", {24'd0, bus.O_VALID}, 32'h00);
        chk("rst_occ", {28'd0, bus.OCC}, 32'd0);
        chk("rst_i_ready", {31'd0, bus.I_READY}, 32'd1);
        @(posedge clk); #1;
        put(3'd3, 8'h5A);
        chk("first_d", {24'd0, bus.D}, 32'h5A);
        chk("first_o_valid", {24'd0, bus.O_VALID}, 32'h08);
        chk("first_occ", {28'd0, bus.OCC}, 32'd1);
        chk("first_a", {24'd0, bus.A}, 32'h00);
        chk("first_h", {24'd0, bus.H}, 32'h00);

        // Fill all lanes, stall a ninth word on C, release it with O_READY[2].
        drain_all();
        for (int s = 0; s < 8; s++) put(3'(s), 8'(8'h10 + s));
        chk("fill_o_valid", {24'd0, bus.O_VALID}, 32'hFF);
        chk("fill_occ", {28'd0, bus.OCC}, 32'd8);
        bus.SEL = 3'd2; bus.I = 8'h99; bus.I_VALID = 1'b1;
        @(negedge clk);
        chk("full_i_ready", {31'd0, bus.I_READY}, 32'd0);
        chk("full_c_hold", {24'd0, bus.C}, 32'h12);
        @(posedge clk); #1;
        chk("full_c_hold2", {24'd0, bus.C}, 32'h12);
        bus.O_READY = 8'h04;
        @(negedge clk);
        chk("refill_i_ready", {31'd0, bus.I_READY}, 32'd1);
        @(posedge clk); #1;
        chk("refill_c", {24'd0, bus.C}, 32'h99);
        chk("refill_o_valid", {24'd0, bus.O_VALID}, 32'hFF);
        chk("refill_occ", {28'd0, bus.OCC}, 32'd8);
        bus.I_VALID = 1'b0; bus.O_READY = 8'h00;

        // Streaming on lane F.
        drain_all();
        bus.O_READY = 8'h20; bus.SEL = 3'd5;
        for (int v = 1; v <= 4; v++) begin
            bus.I = 8'(v); bus.I_VALID = 1'b1;
            @(negedge clk);
            chk("stream_i_ready", {31'd0, bus.I_READY}, 32'd1);
            @(posedge clk); #1;
            chk("stream_f", {24'd0, bus.F}, v);
            chk("stream_occ", {28'd0, bus.OCC}, 32'd1);
        end
        bus.I_VALID = 1'b0;
        tick();
        chk("stream_end_occ", {28'd0, bus.OCC}, 32'd0);

        // Stall on B while G drains.
        bus.O_READY = 8'h00;
        put(3'd1, 8'h21);
        put(3'd6, 8'h26);
        bus.SEL = 3'd1; bus.I = 8'h77; bus.I_VALID = 1'b1; bus.O_READY = 8'h40;
        @(negedge clk);
        chk("stall_i_ready", {31'd0, bus.I_READY}, 32'd0);
        @(posedge clk); #1;
        chk("stall_o_valid", {24'd0, bus.O_VALID}, 32'h02);
        chk("stall_occ", {28'd0, bus.OCC}, 32'd1);
        chk("stall_b", {24'd0, bus.B}, 32'h21);
        bus.O_READY = 8'h02;
        @(negedge clk);
        chk("unstall_i_ready", {31'd0, bus.I_READY}, 32'd1);
        @(posedge clk); #1;
        chk("unstall_b", {24'd0, bus.B}, 32'h77);
        chk("unstall_o_valid", {24'd0, bus.O_VALID}, 32'h02);
        bus.I_VALID = 1'b0;
        drain_all();

        // Reset mid-stream with four lanes valid and a pending transfer.
        for (int s = 0; s < 4; s++) put(3'(s), 8'(8'h30 + s));
        bus.SEL = 3'd4; bus.I = 8'hEE; bus.I_VALID = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_o_valid", {24'd0, bus.O_VALID}, 32'h00);
        chk("midrst_occ", {28'd0, bus.OCC}, 32'd0);
        chk("midrst_a", {24'd0, bus.A}, 32'h00);
        chk("midrst_e", {24'd0, bus.E}, 32'h00);
        rst = 1'b0; bus.I_VALID = 1'b0;
        tick();

`ifdef DEMUX_BCAST_EN
        // Broadcast into an empty block, then blocked by one full lane.
        tb_bcast = 1'b1; bus.I = 8'hC3; bus.I_VALID = 1'b1;
        tick();
        for (int n = 0; n < 8; n++) chk("bcast_lane", {24'd0, lane_out(n)}, 32'hC3);
        chk("bcast_o_valid", {24'd0, bus.O_VALID}, 32'hFF);
        chk("bcast_occ", {28'd0, bus.OCC}, 32'd8);
        drain_all();
        put(3'd4, 8'h01);
        tb_bcast = 1'b1; bus.I_VALID = 1'b1;
        @(negedge clk);
        chk("bcast_blocked", {31'd0, bus.I_READY}, 32'd0);
        @(posedge clk); #1;
        tb_bcast = 1'b0; bus.I_VALID = 1'b0;
`endif

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            bus.I_VALID = ($urandom_range(3) != 0);
            bus.SEL     = 3'($urandom_range(7));
            bus.I       = 8'($urandom);
            bus.O_READY = 8'($urandom);
            rst         = ($urandom_range(99) == 0);
`ifdef DEMUX_BCAST_EN
            tb_bcast    = ($urandom_range(15) == 0);
`endif
            tick();
        end
        rst = 1'b0; bus.I_VALID = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
